// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the instruction cache.
package cache_pkg;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned LINE_WORDS  = 4;
    localparam int unsigned LINE_BITS   = 64;
    localparam int unsigned OFFSET_BITS = 2;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // ib is log2 of the line count; results are right-aligned, caller truncates
    function automatic logic [WORD_SIZE-1:0] addr_tag(input logic [WORD_SIZE-1:0] addr,
                                                      input int unsigned ib);
        return addr >> (OFFSET_BITS + ib);
    endfunction

    function automatic logic [WORD_SIZE-1:0] addr_index(input logic [WORD_SIZE-1:0] addr,
                                                        input int unsigned ib);
        logic [WORD_SIZE-1:0] mask;
        mask = (WORD_SIZE'(1) << ib) - WORD_SIZE'(1);
        return (addr >> OFFSET_BITS) & mask;
    endfunction

    function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [WORD_SIZE-1:0] addr);
        return addr[OFFSET_BITS-1:0];
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: combinational read, one fill write port, bulk invalidate.
module cache_line_store #(
    parameter int unsigned LINE_COUNT = 4,
    parameter int unsigned IB         = 2,
    parameter int unsigned TAG_BITS   = 12,
    parameter int unsigned LINE_BITS  = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IB-1:0]        rd_index,
    output logic                 rd_valid,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IB-1:0]        wr_index,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_data,
    input  logic                 invalidate
);

    logic [LINE_COUNT-1:0] valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINE_COUNT];
    logic [LINE_BITS-1:0]  data_q [LINE_COUNT];

    // Invalidate outranks a same-edge fill so a flushed line never comes back valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (invalidate) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single line read per miss.
module i_cache #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LINE_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_read,
    input  logic [WORD_SIZE-1:0]   cpu_address,
    output logic [WORD_SIZE-1:0]   cpu_data,
    output logic                   cpu_ready,
    input  logic                   flush,
    output logic                   mem_read,
    output logic [WORD_SIZE-1:0]   mem_address,
    input  logic [4*WORD_SIZE-1:0] mem_data,
    input  logic                   mem_signal,
    output logic [WORD_SIZE-1:0]   hit_count,
    output logic [WORD_SIZE-1:0]   miss_count
);
    import cache_pkg::*;

    localparam int unsigned IB       = $clog2(LINE_COUNT);
    localparam int unsigned TAG_BITS = WORD_SIZE - OFFSET_BITS - IB;
    localparam int unsigned L_BITS   = 4 * WORD_SIZE;

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   mem_address_q;
    logic [WORD_SIZE-1:0]   hit_count_q, miss_count_q;

    logic [IB-1:0]          req_index, fill_index;
    logic [TAG_BITS-1:0]    req_tag, fill_tag, line_tag;
    logic [OFFSET_BITS-1:0] req_offset;
    logic                   line_valid, hit;
    logic [L_BITS-1:0]      line_data;
    logic                   fill, hit_inc, miss_inc;

    assign req_index  = IB'(addr_index(cpu_address, IB));
    assign req_tag    = TAG_BITS'(addr_tag(cpu_address, IB));
    assign req_offset = addr_offset(cpu_address);
    assign fill_index = IB'(addr_index(mem_address_q, IB));
    assign fill_tag   = TAG_BITS'(addr_tag(mem_address_q, IB));

    cache_line_store #(
        .LINE_COUNT (LINE_COUNT),
        .IB         (IB),
        .TAG_BITS   (TAG_BITS),
        .LINE_BITS  (L_BITS)
    ) u_store (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_index   (req_index),
        .rd_valid   (line_valid),
        .rd_tag     (line_tag),
        .rd_data    (line_data),
        .wr_en      (fill),
        .wr_index   (fill_index),
        .wr_tag     (fill_tag),
        .wr_data    (mem_data),
        .invalidate (flush)
    );

    assign hit = line_valid && (line_tag == req_tag);

    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        mem_read  = 1'b0;
        fill      = 1'b0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_read) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        hit_inc   = 1'b1;
                    end else begin
                        miss_inc = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_read = 1'b1;
                if (mem_signal) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_address_q <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (hit_inc) begin
                hit_count_q <= hit_count_q + WORD_SIZE'(1);
            end
            if (miss_inc) begin
                miss_count_q  <= miss_count_q + WORD_SIZE'(1);
                mem_address_q <= {cpu_address[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
        end
    end

    assign cpu_data    = cpu_ready ? line_data[32'(req_offset) * WORD_SIZE +: WORD_SIZE] : '0;
    assign mem_address = mem_address_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_i_cache.sv
// Directed bench for i_cache: cold miss, hits, conflict, flush, reset in WAIT, counter wrap.
module tb_i_cache;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read;
    logic [15:0] cpu_address;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        flush;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [63:0] mem_data;
    logic        mem_signal;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i_cache #(
        .WORD_SIZE  (16),
        .LINE_COUNT (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_read    (cpu_read),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_ready   (cpu_ready),
        .flush       (flush),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_signal  (mem_signal),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory image: line 0 is fixed, others are derived from the base address
    function automatic logic [63:0] line_of(input logic [15:0] base);
        if (base == 16'h0000) return {16'h0000, 16'hFFFF, 16'h0001, 16'h9023};
        return {base + 16'h3000, base + 16'h2000, base + 16'h1000, base + 16'hA000};
    endfunction

    // Starts and ends on a falling edge; request stays held for the caller.
    task automatic do_miss(input logic [15:0] addr, input int lat, input logic flush_on_fill);
        logic [15:0] base;
        base        = {addr[15:2], 2'b00};
        cpu_read    = 1'b1;
        cpu_address = addr;
        #1 check("miss_ready", {63'b0, cpu_ready}, 64'd0);
        @(negedge clk);
        for (int i = 0; i < lat; i++) begin
            #1 check("wait_mem_read", {63'b0, mem_read}, 64'd1);
            check("wait_mem_addr", {48'b0, mem_address}, {48'b0, base});
            @(negedge clk);
        end
        mem_signal = 1'b1;
        mem_data   = line_of(base);
        flush      = flush_on_fill;
        @(negedge clk);
        mem_signal = 1'b0;
        mem_data   = '0;
        flush      = 1'b0;
    endtask

    task automatic fetch_hit(input logic [15:0] addr, input logic [15:0] exp);
        cpu_read    = 1'b1;
        cpu_address = addr;
        #1 check("hit_ready", {63'b0, cpu_ready}, 64'd1);
        check("hit_data", {48'b0, cpu_data}, {48'b0, exp});
        check("hit_mem_read", {63'b0, mem_read}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        reset_n     = 1'b0;
        cpu_read    = 1'b0;
        cpu_address = '0;
        flush       = 1'b0;
        mem_data    = '0;
        mem_signal  = 1'b0;
        #1;
        check("rst_ready", {63'b0, cpu_ready}, 64'd0);
        check("rst_data", {48'b0, cpu_data}, 64'd0);
        check("rst_mem_read", {63'b0, mem_read}, 64'd0);
        check("rst_mem_addr", {48'b0, mem_address}, 64'd0);
        check("rst_hits", {48'b0, hit_count}, 64'd0);
        check("rst_misses", {48'b0, miss_count}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Cold miss on line 0
        do_miss(16'h0000, 3, 1'b0);
        #1 check("cold_ready", {63'b0, cpu_ready}, 64'd1);
        check("cold_data", {48'b0, cpu_data}, 64'h9023);
        check("cold_mem_read", {63'b0, mem_read}, 64'd0);
        @(negedge clk);
        check("cold_hits", {48'b0, hit_count}, 64'd1);
        check("cold_misses", {48'b0, miss_count}, 64'd1);

        // Back-to-back hits on the remaining words
        fetch_hit(16'h0001, 16'h0001);
        fetch_hit(16'h0002, 16'hFFFF);
        fetch_hit(16'h0003, 16'h0000);
        cpu_read = 1'b0;
        check("seq_hits", {48'b0, hit_count}, 64'd4);
        check("seq_misses", {48'b0, miss_count}, 64'd1);

        // Conflict on index 0
        do_miss(16'h0010, 2, 1'b0);
        #1 check("conf_data", {48'b0, cpu_data}, 64'hA010);
        @(negedge clk);
        check("conf_misses1", {48'b0, miss_count}, 64'd2);
        do_miss(16'h0000, 1, 1'b0);
        #1 check("conf_data0", {48'b0, cpu_data}, 64'h9023);
        @(negedge clk);
        cpu_read = 1'b0;
        check("conf_misses2", {48'b0, miss_count}, 64'd3);
        check("conf_hits", {48'b0, hit_count}, 64'd6);

        // Flush after fill
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        do_miss(16'h0000, 1, 1'b0);
        #1 check("flush_data", {48'b0, cpu_data}, 64'h9023);
        @(negedge clk);
        cpu_read = 1'b0;
        check("flush_misses", {48'b0, miss_count}, 64'd4);
        check("flush_hits", {48'b0, hit_count}, 64'd7);

        // Flush on the fill edge wins
        do_miss(16'h0006, 2, 1'b1);
        #1 check("ff_ready", {63'b0, cpu_ready}, 64'd0);
        check("ff_idle", {63'b0, mem_read}, 64'd0);
        @(negedge clk);
        #1 check("ff_reread", {63'b0, mem_read}, 64'd1);
        check("ff_addr", {48'b0, mem_address}, 64'h0004);
        check("ff_misses", {48'b0, miss_count}, 64'd6);
        mem_signal = 1'b1;
        mem_data   = line_of(16'h0004);
        @(negedge clk);
        mem_signal = 1'b0;
        mem_data   = '0;
        #1 check("ff_ready2", {63'b0, cpu_ready}, 64'd1);
        check("ff_data2", {48'b0, cpu_data}, 64'h2004);
        @(negedge clk);
        cpu_read = 1'b0;
        check("ff_hits", {48'b0, hit_count}, 64'd8);

        // Reset three cycles into a miss
        cpu_read    = 1'b1;
        cpu_address = 16'h0020;
        repeat (3) @(negedge clk);
        #1 check("rw_mem_read", {63'b0, mem_read}, 64'd1);
        #2 reset_n = 1'b0;
        #1 check("rw_drop", {63'b0, mem_read}, 64'd0);
        check("rw_hits", {48'b0, hit_count}, 64'd0);
        check("rw_misses", {48'b0, miss_count}, 64'd0);
        check("rw_data", {48'b0, cpu_data}, 64'd0);
        @(negedge clk);
        cpu_read = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        mem_signal = 1'b1;
        mem_data   = line_of(16'h0020);
        @(negedge clk);
        mem_signal = 1'b0;
        mem_data   = '0;
        for (int i = 0; i < 5; i++) begin
            cpu_address = (i == 4) ? 16'h0020 : 16'(i * 4);
            cpu_read    = 1'b1;
            #1 check("rw_invalid", {63'b0, cpu_ready}, 64'd0);
            cpu_read = 1'b0;
            @(negedge clk);
        end
        check("rw_no_miss", {48'b0, miss_count}, 64'd0);
        check("rw_idle", {63'b0, mem_read}, 64'd0);

        // Hit counter wrap: hold a hitting request until the counter saturates the width
        do_miss(16'h0000, 1, 1'b0);
        for (int n = 0; n < 70000 && hit_count != 16'hFFFF; n++) begin
            @(negedge clk);
        end
        check("wrap_reach", {48'b0, hit_count}, 64'hFFFF);
        #1 check("wrap_ready", {63'b0, cpu_ready}, 64'd1);
        @(negedge clk);
        cpu_read = 1'b0;
        check("wrap_hits", {48'b0, hit_count}, 64'd0);
        check("wrap_misses", {48'b0, miss_count}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
